// File: rtl/output_sram_wr_arbiter_pkg.sv
// Shared types and sizing for the output-SRAM write arbiter.
// Holds the bank packet layout, FSM states and address helper.
package output_sram_wr_arbiter_pkg;

    localparam int FV_SIZE     = 16;
    localparam int MAX_FV_NUM  = 8;
    localparam int MAX_NODE_ID = 16;

    localparam int BPN    = MAX_FV_NUM / 2;
    localparam int NODE_W = $clog2(MAX_NODE_ID);
    localparam int BEAT_W = $clog2(BPN);
    localparam int ADDR_W = NODE_W + BEAT_W;
    localparam int CNT_W  = $clog2(BPN + 1);

    typedef struct packed {
        logic                    req;
        logic                    Grant_valid;
        logic                    sos;
        logic                    eos;
        logic [1:0][FV_SIZE-1:0] data;
        logic [NODE_W-1:0]       nodeid;
    } Bank_Req2Req_Output_SRAM;

    typedef enum logic [1:0] {
        OA_IDLE,
        OA_GRANT,
        OA_RECV
    } OSRAM_ARB_STATE;

    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [NODE_W-1:0] node,
        input logic [CNT_W-1:0]  beat
    );
        return ADDR_W'(node) * ADDR_W'(BPN) + ADDR_W'(beat);
    endfunction

endpackage

// File: rtl/output_sram_wr_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer,
// searched cyclically; purely combinational.
module output_sram_wr_arbiter_rr_arbiter #(
    parameter int NUM_BANKS = 4
) (
    input  logic [NUM_BANKS-1:0]         req,
    input  logic [$clog2(NUM_BANKS)-1:0] rr_ptr,
    output logic                         any_req,
    output logic [NUM_BANKS-1:0]         win_onehot,
    output logic [$clog2(NUM_BANKS)-1:0] win_idx
);

    localparam int IDX_W = $clog2(NUM_BANKS);

    // Scan from rr_ptr and keep the first hit
    always_comb begin
        int c;
        any_req    = 1'b0;
        win_onehot = '0;
        win_idx    = '0;
        c          = 0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            c = (int'(rr_ptr) + k) % NUM_BANKS;
            if (!any_req && req[c]) begin
                any_req       = 1'b1;
                win_onehot[c] = 1'b1;
                win_idx       = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/output_sram_wr_arbiter.sv
// Grants one edge-buffer bank at a time and streams its
// sos..eos beats into the output SRAM at nodeid*BPN + beat.
module output_sram_wr_arbiter
    import output_sram_wr_arbiter_pkg::*;
#(
    parameter int NUM_BANKS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  Bank_Req2Req_Output_SRAM bank_pkt [NUM_BANKS],
    output logic [NUM_BANKS-1:0]    req_grant,
    output logic                    sram_we,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [2*FV_SIZE-1:0]    sram_wdata,
    output logic                    busy,
    output logic                    proto_err
);

    localparam int IDX_W = $clog2(NUM_BANKS);

    OSRAM_ARB_STATE          state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        win_q, win_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [NODE_W-1:0]       node_q, node_d;
    logic [NUM_BANKS-1:0]    grant_q, grant_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [2*FV_SIZE-1:0]    wdata_q, wdata_d;
    logic                    err_q, err_d;

    logic [NUM_BANKS-1:0]    req_vec;
    logic                    any_req;
    logic [NUM_BANKS-1:0]    win_onehot;
    logic [IDX_W-1:0]        win_idx;

    // Gather request bits from every bank
    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            req_vec[i] = bank_pkt[i].req;
        end
    end

    output_sram_wr_arbiter_rr_arbiter #(
        .NUM_BANKS (NUM_BANKS)
    ) u_rr_arbiter (
        .req        (req_vec),
        .rr_ptr     (rr_ptr_q),
        .any_req    (any_req),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        beat_cnt_d = beat_cnt_q;
        node_d     = node_q;
        grant_d    = '0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;

        unique case (state_q)
            OA_IDLE: begin
                beat_cnt_d = '0;
                if (any_req) begin
                    grant_d  = win_onehot;
                    win_d    = win_idx;
                    rr_ptr_d = (win_idx == IDX_W'(NUM_BANKS - 1)) ?
                               '0 : win_idx + 1'b1;
                    state_d  = OA_GRANT;
                end
            end
            OA_GRANT: begin
                if (bank_pkt[win_q].Grant_valid && bank_pkt[win_q].sos) begin
                    we_d       = 1'b1;
                    addr_d     = beat_addr(bank_pkt[win_q].nodeid, '0);
                    wdata_d    = bank_pkt[win_q].data;
                    node_d     = bank_pkt[win_q].nodeid;
                    beat_cnt_d = CNT_W'(1);
                    state_d    = bank_pkt[win_q].eos ? OA_IDLE : OA_RECV;
                end else begin
                    err_d   = 1'b1;
                    state_d = OA_IDLE;
                end
            end
            OA_RECV: begin
                // Missing valid, a second sos or a beat past the
                // node's last slot all abort without writing.
                if (!bank_pkt[win_q].Grant_valid ||
                    bank_pkt[win_q].sos ||
                    beat_cnt_q == CNT_W'(BPN)) begin
                    err_d   = 1'b1;
                    state_d = OA_IDLE;
                end else begin
                    we_d       = 1'b1;
                    addr_d     = beat_addr(node_q, beat_cnt_q);
                    wdata_d    = bank_pkt[win_q].data;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (bank_pkt[win_q].eos) begin
                        state_d = OA_IDLE;
                    end
                end
            end
            default: state_d = OA_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= OA_IDLE;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            beat_cnt_q <= '0;
            node_q     <= '0;
            grant_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            beat_cnt_q <= beat_cnt_d;
            node_q     <= node_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign req_grant  = grant_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign proto_err  = err_q;
    assign busy       = (state_q != OA_IDLE);

endmodule

// File: tb/tb_output_sram_wr_arbiter.sv
// Directed bench for the output-SRAM write arbiter.
// Bank behaviour is scripted step by step against fixed expectations.
module tb_output_sram_wr_arbiter;
    import output_sram_wr_arbiter_pkg::*;

    localparam int NB = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    Bank_Req2Req_Output_SRAM bank_pkt [NB];
    logic [NB-1:0]           req_grant;
    logic                    sram_we;
    logic [ADDR_W-1:0]       sram_addr;
    logic [2*FV_SIZE-1:0]    sram_wdata;
    logic                    busy;
    logic                    proto_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    output_sram_wr_arbiter #(
        .NUM_BANKS (NB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bank_pkt   (bank_pkt),
        .req_grant  (req_grant),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .busy       (busy),
        .proto_err  (proto_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int b, input logic gv, input logic sos,
                         input logic eos, input logic [FV_SIZE-1:0] d0,
                         input logic [FV_SIZE-1:0] d1,
                         input logic [NODE_W-1:0] nid);
        bank_pkt[b].Grant_valid = gv;
        bank_pkt[b].sos         = sos;
        bank_pkt[b].eos         = eos;
        bank_pkt[b].data[0]     = d0;
        bank_pkt[b].data[1]     = d1;
        bank_pkt[b].nodeid      = nid;
    endtask

    task automatic quiet(input int b);
        drive(b, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wr(input string tag, input int a,
                      input logic [FV_SIZE-1:0] d0,
                      input logic [FV_SIZE-1:0] d1);
        chk({tag, "_we"}, 64'(sram_we), 64'(1));
        chk({tag, "_addr"}, 64'(sram_addr), 64'(a));
        chk({tag, "_data"}, 64'(sram_wdata), {32'h0, d1, d0});
    endtask

    task automatic gnt(input string tag, input logic [NB-1:0] exp);
        chk(tag, 64'(req_grant), 64'(exp));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < NB; i++) begin
            bank_pkt[i] = '0;
        end
        tick();
        gnt("rst_grant", '0);
        chk("rst_we", 64'(sram_we), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(proto_err), 64'(0));
        reset = 1'b1;

        // 1: four-beat node 5 from bank 1
        bank_pkt[1].req = 1'b1;
        tick();
        gnt("t1_grant", 4'b0010);
        chk("t1_busy", 64'(busy), 64'(1));
        bank_pkt[1].req = 1'b0;
        drive(1, 1, 1, 0, 16'h1000, 16'h2000, 5);
        tick();
        gnt("t1_grant_off", '0);
        wr("t1_b0", 20, 16'h1000, 16'h2000);
        drive(1, 1, 0, 0, 16'h1001, 16'h2001, 5);
        tick();
        wr("t1_b1", 21, 16'h1001, 16'h2001);
        drive(1, 1, 0, 0, 16'h1002, 16'h2002, 9);
        tick();
        wr("t1_b2", 22, 16'h1002, 16'h2002);
        drive(1, 1, 0, 1, 16'h1003, 16'h2003, 5);
        tick();
        wr("t1_b3", 23, 16'h1003, 16'h2003);
        chk("t1_busy_end", 64'(busy), 64'(0));
        quiet(1);
        tick();
        chk("t1_we_end", 64'(sram_we), 64'(0));
        chk("t1_err", 64'(proto_err), 64'(0));

        // 2+3: banks 0,2,3 together, two-FV nodes, bank 0 re-requests
        pulse_reset();
        bank_pkt[0].req = 1'b1;
        bank_pkt[2].req = 1'b1;
        bank_pkt[3].req = 1'b1;
        tick();
        gnt("t2_g0", 4'b0001);
        bank_pkt[0].req = 1'b0;
        drive(0, 1, 1, 1, 16'h3000, 16'h4000, 3);
        tick();
        wr("t3_w12", 12, 16'h3000, 16'h4000);
        gnt("t2_gap0", '0);
        chk("t3_idle", 64'(busy), 64'(0));
        quiet(0);
        tick();
        gnt("t3_g2_2cyc", 4'b0100);
        chk("t3_we_off", 64'(sram_we), 64'(0));
        bank_pkt[2].req = 1'b0;
        bank_pkt[0].req = 1'b1;
        drive(2, 1, 1, 1, 16'h3002, 16'h4002, 6);
        tick();
        wr("t2_w24", 24, 16'h3002, 16'h4002);
        gnt("t2_gap2", '0);
        quiet(2);
        tick();
        gnt("t2_g3", 4'b1000);
        bank_pkt[3].req = 1'b0;
        drive(3, 1, 1, 1, 16'h3003, 16'h4003, 1);
        tick();
        wr("t2_w4", 4, 16'h3003, 16'h4003);
        quiet(3);
        tick();
        gnt("t2_g0_again", 4'b0001);
        bank_pkt[0].req = 1'b0;
        drive(0, 1, 1, 1, 16'h3010, 16'h4010, 2);
        tick();
        wr("t2_w8", 8, 16'h3010, 16'h4010);
        quiet(0);
        tick();
        gnt("t2_none", '0);

        // 4: winner (bank 1) never answers, bank 2 still served
        bank_pkt[1].req = 1'b1;
        bank_pkt[2].req = 1'b1;
        tick();
        gnt("t4_g1", 4'b0010);
        bank_pkt[1].req = 1'b0;
        tick();
        chk("t4_err", 64'(proto_err), 64'(1));
        chk("t4_we", 64'(sram_we), 64'(0));
        chk("t4_busy", 64'(busy), 64'(0));
        tick();
        gnt("t4_g2", 4'b0100);
        bank_pkt[2].req = 1'b0;
        drive(2, 1, 1, 1, 16'h5002, 16'h6002, 7);
        tick();
        wr("t4_w28", 28, 16'h5002, 16'h6002);
        chk("t4_err_sticky", 64'(proto_err), 64'(1));
        quiet(2);
        tick();

        // 5: overflow, five beats with no eos
        pulse_reset();
        chk("t5_err_clr", 64'(proto_err), 64'(0));
        bank_pkt[0].req = 1'b1;
        tick();
        gnt("t5_g0", 4'b0001);
        bank_pkt[0].req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, k == 0, 0, FV_SIZE'(16'h7000 + k),
                  FV_SIZE'(16'h8000 + k), 2);
            tick();
            wr($sformatf("t5_b%0d", k), 8 + k, FV_SIZE'(16'h7000 + k),
               FV_SIZE'(16'h8000 + k));
        end
        drive(0, 1, 0, 0, 16'h7004, 16'h8004, 2);
        tick();
        chk("t5_no5th", 64'(sram_we), 64'(0));
        chk("t5_err", 64'(proto_err), 64'(1));
        chk("t5_idle", 64'(busy), 64'(0));
        quiet(0);
        tick();
        chk("t5_we_after", 64'(sram_we), 64'(0));

        // 6: reset during beat 2 of bank 2's stream
        bank_pkt[2].req = 1'b1;
        tick();
        gnt("t6_g2", 4'b0100);
        bank_pkt[2].req = 1'b0;
        drive(2, 1, 1, 0, 16'h9000, 16'hA000, 1);
        tick();
        wr("t6_b0", 4, 16'h9000, 16'hA000);
        drive(2, 1, 0, 0, 16'h9001, 16'hA001, 1);
        tick();
        wr("t6_b1", 5, 16'h9001, 16'hA001);
        drive(2, 1, 0, 0, 16'h9002, 16'hA002, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_we_now", 64'(sram_we), 64'(0));
        chk("t6_busy_now", 64'(busy), 64'(0));
        chk("t6_addr_now", 64'(sram_addr), 64'(0));
        chk("t6_err_now", 64'(proto_err), 64'(0));
        tick();
        chk("t6_we_held", 64'(sram_we), 64'(0));
        reset = 1'b1;
        tick();
        chk("t6_we_rel", 64'(sram_we), 64'(0));
        chk("t6_busy_rel", 64'(busy), 64'(0));
        quiet(2);
        bank_pkt[0].req = 1'b1;
        bank_pkt[3].req = 1'b1;
        tick();
        gnt("t6_ptr0", 4'b0001);
        bank_pkt[0].req = 1'b0;
        drive(0, 1, 1, 1, 16'hB000, 16'hC000, 0);
        tick();
        wr("t6_w0", 0, 16'hB000, 16'hC000);
        quiet(0);
        tick();
        gnt("t6_g3", 4'b1000);
        bank_pkt[3].req = 1'b0;
        drive(3, 1, 1, 1, 16'hB003, 16'hC003, 15);
        tick();
        wr("t6_w60", 60, 16'hB003, 16'hC003);
        quiet(3);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
